// File: rtl/aska_spi_rdbk_if.sv
// SPI pad-side bundle for the ASKA readback transmitter.
// The master modport is the bus master (chip select, MOSI); the slave modport is the ASIC side.
interface aska_spi_rdbk_if;
   logic SPI_CS;
   logic SPI_MOSI;
   logic SPI_MISO;
   logic SPI_MISO_oe;
   logic rd_active;

   modport master (
      output SPI_CS,
      output SPI_MOSI,
      input  SPI_MISO,
      input  SPI_MISO_oe,
      input  rd_active
   );

   modport slave (
      input  SPI_CS,
      input  SPI_MOSI,
      output SPI_MISO,
      output SPI_MISO_oe,
      output rd_active
   );
endinterface

// File: rtl/aska_spi_rdbk.sv
// Mode 0 SPI readback transmitter: decodes the command byte of a 40-bit frame and
// shifts the selected configuration word (or CHIP_ID) out on MISO, MSB first.
module aska_spi_rdbk #(
   parameter logic [31:0] CHIP_ID    = 32'hA5CA_0001,
   parameter int          FRAME_BITS = 40
) (
   input  logic               SPI_Clk,
   input  logic               resetn,
   aska_spi_rdbk_if.slave     spi,
   input  logic [31:0]        conf0,
   input  logic [31:0]        conf1,
   input  logic [31:0]        ele1,
   input  logic [31:0]        ele2
);

   localparam logic [1:0] ST_CMD    = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;
   localparam logic [1:0] ST_IGNORE = 2'd3;

   localparam logic [5:0] CMD_BITS  = 6'd8;
   localparam logic [5:0] CMD_LAST  = 6'd7;
   localparam logic [5:0] DATA_LAST = 6'(FRAME_BITS - 1);
   localparam logic [5:0] CNT_MAX   = 6'(FRAME_BITS + 1);

   logic [1:0]  state_reg, state_next;
   logic [5:0]  bit_cnt_reg, bit_cnt_next;
   // The eighth command bit is decoded straight from MOSI, so only seven are ever stored.
   logic [6:0]  cmd_sr_reg, cmd_sr_next;
   logic [31:0] tx_sr_reg, tx_sr_next;
   logic        armed_reg;
   logic        miso_reg;
   logic        oe_reg;

   logic        frame_rst_n;
   logic        cmd_rd;
   logic        cmd_id;
   logic [1:0]  cmd_addr;
   logic [31:0] sel_word;

   assign frame_rst_n = resetn & ~spi.SPI_CS;

   assign cmd_rd   = cmd_sr_reg[6];
   assign cmd_id   = cmd_sr_reg[1];
   assign cmd_addr = {cmd_sr_reg[0], spi.SPI_MOSI};

   always_comb begin
      sel_word = conf0;
      if (cmd_id) begin
         sel_word = CHIP_ID;
      end else begin
         case (cmd_addr)
            2'b00:   sel_word = conf0;
            2'b01:   sel_word = conf1;
            2'b10:   sel_word = ele1;
            default: sel_word = ele2;
         endcase
      end
   end

   // A reset mid-frame disarms the frame logic until chip select has been seen high.
   always_ff @(posedge SPI_Clk or negedge resetn or posedge spi.SPI_CS) begin
      if (!resetn) begin
         armed_reg <= 1'b0;
      end else if (spi.SPI_CS) begin
         armed_reg <= 1'b1;
      end
   end

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      cmd_sr_next  = cmd_sr_reg;
      tx_sr_next   = tx_sr_reg;
      if (armed_reg) begin
         if (bit_cnt_reg != CNT_MAX) begin
            bit_cnt_next = bit_cnt_reg + 6'd1;
         end
         if (bit_cnt_reg < CMD_BITS) begin
            cmd_sr_next = {cmd_sr_reg[5:0], spi.SPI_MOSI};
         end
         case (state_reg)
            ST_CMD: begin
               if (bit_cnt_reg == CMD_LAST) begin
                  if (cmd_rd) begin
                     tx_sr_next = sel_word;
                     state_next = ST_DATA;
                  end else begin
                     state_next = ST_IGNORE;
                  end
               end
            end
            ST_DATA: begin
               tx_sr_next = {tx_sr_reg[30:0], 1'b0};
               if (bit_cnt_reg == DATA_LAST) begin
                  state_next = ST_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge SPI_Clk or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         state_reg   <= ST_CMD;
         bit_cnt_reg <= 6'd0;
         cmd_sr_reg  <= 7'd0;
         tx_sr_reg   <= 32'd0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         cmd_sr_reg  <= cmd_sr_next;
         tx_sr_reg   <= tx_sr_next;
      end
   end

   // MISO launches on the falling edge so the master samples mid-bit on the next rise.
   always_ff @(negedge SPI_Clk or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         miso_reg <= 1'b0;
         oe_reg   <= 1'b0;
      end else begin
         miso_reg <= (state_reg == ST_DATA) ? tx_sr_reg[31] : 1'b0;
         if (state_reg == ST_DATA) begin
            oe_reg <= 1'b1;
         end
      end
   end

   assign spi.SPI_MISO    = miso_reg;
   assign spi.SPI_MISO_oe = oe_reg;
   assign spi.rd_active   = (state_reg == ST_DATA);

endmodule

// File: tb/tb_aska_spi_rdbk.sv
// Directed bench for aska_spi_rdbk: drives Mode 0 frames, records MISO/oe/rd_active
// per clock and compares against hand-derived bit patterns.
module tb_aska_spi_rdbk;

   logic        SPI_Clk = 1'b0;
   logic        resetn  = 1'b0;
   logic [31:0] conf0   = 32'h0;
   logic [31:0] conf1   = 32'h0;
   logic [31:0] ele1    = 32'h0;
   logic [31:0] ele2    = 32'h0;

   aska_spi_rdbk_if spi ();

   aska_spi_rdbk dut (
      .SPI_Clk (SPI_Clk),
      .resetn  (resetn),
      .spi     (spi),
      .conf0   (conf0),
      .conf1   (conf1),
      .ele1    (ele1),
      .ele2    (ele2)
   );

   always #5 SPI_Clk = ~SPI_Clk;

   int checks = 0;
   int errors = 0;

   logic [63:0] miso_pat;
   logic [63:0] oe_pat;
   logic [63:0] rd_pat;
   logic [31:0] rx_word;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end else begin
         $display("ok   %s value=%h", tag, obs);
      end
   endtask

   function automatic logic [63:0] mask(input int lo, input int hi);
      logic [63:0] m;
      m = '0;
      for (int k = lo; k <= hi; k++) m[k] = 1'b1;
      return m;
   endfunction

   // MISO seen after falling edge k is the bit the master samples on rising edge k+1.
   function automatic logic [63:0] wpat(input logic [31:0] w, input int lo, input int hi);
      logic [63:0] p;
      p = '0;
      for (int k = lo; k <= hi; k++) p[k] = w[39-k];
      return p;
   endfunction

   task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nclk,
                        input int rst_at, input int chg_at);
      logic [39:0] bits;
      bits     = {cmd, data};
      miso_pat = '0;
      oe_pat   = '0;
      rd_pat   = '0;
      rx_word  = '0;
      @(negedge SPI_Clk); #1;
      spi.SPI_CS   = 1'b0;
      spi.SPI_MOSI = bits[39];
      for (int k = 1; k <= nclk; k++) begin
         @(posedge SPI_Clk); #1;
         rd_pat[k] = spi.rd_active;
         if (k == rst_at) resetn = 1'b0;
         if (k == chg_at) conf0 = 32'h0;
         @(negedge SPI_Clk); #1;
         miso_pat[k] = spi.SPI_MISO;
         oe_pat[k]   = spi.SPI_MISO_oe;
         if (k == rst_at) resetn = 1'b1;
         if (k >= 8 && k <= 39) rx_word[39-k] = spi.SPI_MISO;
         spi.SPI_MOSI = (k < 40) ? bits[39-k] : 1'b0;
      end
      spi.SPI_CS   = 1'b1;
      spi.SPI_MOSI = 1'b0;
   endtask

   task automatic idle();
      repeat (2) @(negedge SPI_Clk);
   endtask

   // Stand-in for the write receiver: commits complete write frames.
   task automatic write_frame(input string tag, input logic [7:0] cmd, input logic [31:0] data);
      frame(cmd, data, 40, 0, 0);
      chk({tag, " miso"}, miso_pat, 64'h0);
      chk({tag, " oe"},   oe_pat,   64'h0);
      chk({tag, " rd"},   rd_pat,   64'h0);
      case (cmd[1:0])
         2'b00:   conf0 = data;
         2'b01:   conf1 = data;
         2'b10:   ele1  = data;
         default: ele2  = data;
      endcase
      idle();
   endtask

   task automatic read_frame(input string tag, input logic [7:0] cmd, input logic [31:0] w,
                             input int nclk, input int chg_at);
      frame(cmd, 32'h0, nclk, 0, chg_at);
      chk({tag, " word"}, {32'h0, rx_word}, {32'h0, w});
      chk({tag, " miso"}, miso_pat, wpat(w, 8, 39));
      chk({tag, " oe"},   oe_pat,   mask(8, nclk));
      chk({tag, " rd"},   rd_pat,   mask(8, 39));
      idle();
   endtask

   initial begin
      spi.SPI_CS   = 1'b1;
      spi.SPI_MOSI = 1'b0;
      repeat (2) @(negedge SPI_Clk);
      #1;
      chk("reset outputs", {61'h0, spi.SPI_MISO, spi.SPI_MISO_oe, spi.rd_active}, 64'h0);
      resetn = 1'b1;
      idle();

      write_frame("t1 write conf1", 8'h01, 32'h1234_5678);
      read_frame("t1 read conf1", 8'h81, 32'h1234_5678, 40, 0);

      ele2 = 32'hFFFF_0000;
      read_frame("t2 read id", 8'h84, 32'hA5CA_0001, 40, 0);
      read_frame("t2 read ele2", 8'h83, 32'hFFFF_0000, 40, 0);

      write_frame("t3 write ele1", 8'h02, 32'hDEAD_BEEF);
      read_frame("t3 read ele1", 8'h82, 32'hDEAD_BEEF, 40, 0);

      conf0 = 32'hCAFE_F00D;
      read_frame("t4 snapshot conf0", 8'h80, 32'hCAFE_F00D, 40, 20);

      frame(8'h81, 32'h0, 20, 0, 0);
      chk("t5 abort miso", miso_pat, wpat(32'h1234_5678, 8, 20));
      chk("t5 abort oe",   oe_pat,   mask(8, 20));
      chk("t5 abort rd",   rd_pat,   mask(8, 20));
      #1;
      chk("t5 abort clear", {62'h0, spi.SPI_MISO_oe, spi.rd_active}, 64'h0);
      idle();
      read_frame("t5 read after abort", 8'h81, 32'h1234_5678, 40, 0);
      read_frame("t5 long read", 8'h84, 32'hA5CA_0001, 44, 0);

      frame(8'h83, 32'h0, 40, 15, 0);
      chk("t6 reset miso", miso_pat, wpat(32'hFFFF_0000, 8, 14));
      chk("t6 reset oe",   oe_pat,   mask(8, 14));
      chk("t6 reset rd",   rd_pat,   mask(8, 15));
      idle();
      read_frame("t6 read after reset", 8'h82, 32'hDEAD_BEEF, 40, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
